pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Controls the reset/lock cycle of the pixel-clock PLL (50 MHz reference in, lock out). Holds PLL reset for a minimum time after power-up, waits for lock with a timeout, qualifies lock stability and retries on failure. Only then does it release the synchronous reset for logic clocked by the PLL outputs. Runs entirely in the free-running reference clock domain, sitting between the board reset and the PLL instance.

Parameters:
RST_HOLD_CYCLES, 1000, clkin cycles pll_reset is held high per attempt (20 us @ 50 MHz)
LOCK_TIMEOUT, 50000, clkin cycles to wait for lock before retrying (1 ms)
LOCK_STABLE_CYCLES, 256, consecutive synchronized-lock-high cycles needed to qualify lock
RELEASE_DELAY, 16, cycles between qualified lock and sys_rst deassertion
MAX_RETRIES, 7, timeouts/losses tolerated before entering FAIL (1..15)

Ports:
clkin  in  1  free-running reference clock, the only clock
reset  in  1  synchronous, active-high block reset
lock_in  in  1  PLL lock, asynchronous to clkin
force_relock  in  1  single-cycle request to restart the sequence
pll_reset  out  1  drives PLL reset, active-high
sys_rst  out  1  downstream synchronous reset, active-high
ready  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_cnt  out  4  attempts consumed in current sequence
lol_sticky  out  1  set on lock loss in RUN, cleared by reset or force_relock
state  out  3  HOLD=0, WAIT=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5

Behaviour:
- One clock, clkin; reset synchronous, active-high. All outputs registered.
- Reset (priority over everything): state=HOLD, counter=0, pll_reset=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lol_sticky=0, sync flops=0.
- lock_in passes a 2-flop synchronizer (lock_s); 2-cycle latency, included in all counts below.
- Single 16..17-bit counter, cleared on every state entry.
- HOLD: pll_reset=1, sys_rst=1. After RST_HOLD_CYCLES cycles in HOLD -> WAIT, with pll_reset=0 from the first WAIT cycle.
- WAIT: lock_s=1 -> STABLE. If LOCK_TIMEOUT cycles elapse without lock, apply the retry rule.
- STABLE: lock_s=0 -> WAIT (timeout restarts). LOCK_STABLE_CYCLES consecutive high cycles -> RELEASE.
- RELEASE: sys_rst stays 1. lock_s=0 -> retry rule. After RELEASE_DELAY cycles -> RUN.
- RUN: sys_rst=0, ready=1. lock_s=0 -> HOLD, retry_cnt=0, lol_sticky=1. sys_rst=1 and ready=0 in the first HOLD cycle.
- Retry rule: if retry_cnt==MAX_RETRIES -> FAIL, otherwise retry_cnt+1 and -> HOLD.
- FAIL: pll_reset=1, sys_rst=1, fail=1. The block stays in FAIL until reset or force_relock.
- force_relock in any state -> HOLD, retry_cnt=0, lol_sticky=0. It overrides a same-cycle lock event or timeout.
- retry_cnt saturates per the retry rule and never wraps.
- sys_rst is never 0 unless state==RUN. pll_reset is 1 only in HOLD and FAIL.
- Lock glitches shorter than 2 cycles may be missed; this is acceptable.

Test Plan:
The bench uses RST_HOLD=8, LOCK_TIMEOUT=32, LOCK_STABLE=4, RELEASE_DELAY=2 and MAX_RETRIES=2.
1. Release reset at cycle 0, lock_in high from cycle 12 -> pll_reset falls at cycle 8. STABLE is entered 2 cycles after the synchronized edge. sys_rst falls and ready rises 4+2 cycles later. retry_cnt=0.
2. lock_in held low -> timeouts at each WAIT end give retry_cnt 1, then 2. The third timeout gives FAIL with fail=1, pll_reset=1 and sys_rst=1, held for 200 cycles.
3. In RUN, drop lock_in for 3 cycles -> HOLD with sys_rst=1, ready=0, lol_sticky=1, retry_cnt=0. After lock returns, RUN is reached again with lol_sticky still 1.
4. During STABLE, pulse lock_in low for 2 cycles after 3 high -> return to WAIT with no retry increment. Full qualification after lock returns.
5. In FAIL, pulse force_relock -> HOLD the next cycle with retry_cnt=0, fail=0 and lol_sticky=0. A normal lock then reaches RUN.
6. Assert reset mid-RELEASE, and on the same cycle as force_relock -> reset state values the next cycle. pll_reset stays high for the full 8 cycles.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences the reset/lock cycle of the pixel-clock PLL from the free-running
// reference clock. The PLL is held in reset for a minimum time, then lock is
// awaited with a timeout, qualified for stability and given a short release
// delay before the downstream synchronous reset is dropped. Timeouts and lock
// losses before RUN consume retries; exhausting them parks the block in FAIL.
//
// Ports:
//   clkin        in   reference clock, the only clock of this block
//   reset        in   synchronous active-high block reset
//   lock_in      in   PLL lock, asynchronous to clkin (synchronized here)
//   force_relock in   single-cycle request to restart the whole sequence
//   pll_reset    out  PLL reset, high in HOLD and FAIL only
//   sys_rst      out  downstream reset, low only in RUN
//   ready        out  high only in RUN
//   fail         out  high only in FAIL
//   retry_cnt    out  attempts consumed in the current sequence
//   lol_sticky   out  lock was lost while in RUN
//   state        out  HOLD=0 WAIT=1 STABLE=2 RELEASE=3 RUN=4 FAIL=5
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 1000,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned RELEASE_DELAY      = 16,
  parameter int unsigned MAX_RETRIES        = 7
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock_in,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic       lol_sticky,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STABLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam int CNT_W = 17;

  // The counter holds (cycles spent in the state - 1), so each exit compares
  // against the last cycle index of the state.
  localparam logic [CNT_W-1:0] HOLD_LAST    = 17'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = 17'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = 17'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = 17'(RELEASE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lol_q, lol_d;
  logic             meta_q, lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             restart_s;
  state_e           retry_state_s;
  logic [3:0]       retry_inc_s;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clkin) begin
    if (reset) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= lock_in;
      lock_s_q <= meta_q;
    end
  end

  // Outcome of a failed attempt: another HOLD with one more retry, or FAIL
  // once the budget is spent (the count never goes past MAX_RETRIES).
  always_comb begin
    retry_state_s = ST_HOLD;
    retry_inc_s   = retry_q;
    if (retry_q == RETRY_MAX) begin
      retry_state_s = ST_FAIL;
      retry_inc_s   = retry_q;
    end else begin
      retry_state_s = ST_HOLD;
      retry_inc_s   = retry_q + 4'd1;
    end
  end

  // Next-state, retry/loss bookkeeping and next registered outputs.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    lol_d     = lol_q;
    restart_s = 1'b0;
    if (force_relock) begin
      // Overrides any lock event or timeout seen in the same cycle.
      state_d   = ST_HOLD;
      retry_d   = 4'd0;
      lol_d     = 1'b0;
      restart_s = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = ST_WAIT;
          else                    state_d = ST_HOLD;
        end
        ST_WAIT: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = retry_state_s;
            retry_d = retry_inc_s;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_STABLE: begin
          // A dropout just returns to WAIT, whose timeout starts over.
          if (!lock_s_q)                  state_d = ST_WAIT;
          else if (cnt_q == STABLE_LAST)  state_d = ST_RELEASE;
          else                            state_d = ST_STABLE;
        end
        ST_RELEASE: begin
          if (!lock_s_q) begin
            state_d = retry_state_s;
            retry_d = retry_inc_s;
          end else if (cnt_q == RELEASE_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end
        ST_RUN: begin
          // Lock loss after a good sequence starts a fresh one.
          if (!lock_s_q) begin
            state_d = ST_HOLD;
            retry_d = 4'd0;
            lol_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_HOLD;
          retry_d = 4'd0;
        end
      endcase
    end

    // The counter restarts on every state entry, including HOLD re-entry.
    if (restart_s || (state_d != state_q)) begin
      cnt_d = 17'd0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 17'd1;
    end

    pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
    sys_rst_d   = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counter, bookkeeping and output registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= 17'd0;
      retry_q     <= 4'd0;
      lol_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;
  assign lol_sticky = lol_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pll_lock_sequencer with small timing parameters.
// A reference model derives every cycle's expected outputs from a log of
// sampled lock values and the edge at which each phase was entered.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int P_HOLD_N    = 8;
  localparam int P_TIMEOUT   = 32;
  localparam int P_STABLE_N  = 4;
  localparam int P_RELEASE_N = 2;
  localparam int P_MAXR      = 2;

  localparam int HOLD = 0, WAIT = 1, STABLE = 2, RELEASE = 3, RUN = 4, FAILST = 5;

  logic       clkin = 1'b0;
  logic       reset, lock_in, force_relock;
  logic       pll_reset, sys_rst, ready, fail, lol_sticky;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES   (P_HOLD_N),
    .LOCK_TIMEOUT      (P_TIMEOUT),
    .LOCK_STABLE_CYCLES(P_STABLE_N),
    .RELEASE_DELAY     (P_RELEASE_N),
    .MAX_RETRIES       (P_MAXR)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .lock_in     (lock_in),
    .force_relock(force_relock),
    .pll_reset   (pll_reset),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .lol_sticky  (lol_sticky),
    .state       (state)
  );

  always #5 clkin = ~clkin;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  int  m_phase, m_start, m_edge, m_retries;
  bit  m_lol, m_valid;
  bit  lock_log[$];   // lock_in value sampled at each edge since reset

  function automatic void m_goto(int ph);
    m_phase = ph;
    m_start = m_edge;
  endfunction

  function automatic void m_retry();
    if (m_retries == P_MAXR) m_goto(FAILST);
    else begin
      m_retries++;
      m_goto(HOLD);
    end
  endfunction

  function automatic void model_edge(bit rst, bit fr, bit lk);
    bit ls;
    int el;
    m_edge++;
    if (rst) begin
      m_valid = 1; m_retries = 0; m_lol = 0;
      m_goto(HOLD);
      lock_log.delete();
      lock_log.push_back(1'b0);
      lock_log.push_back(1'b0);
      return;
    end
    if (!m_valid) return;
    // synchronized lock seen by the logic = value sampled two edges earlier
    ls = lock_log[lock_log.size() - 2];
    lock_log.push_back(lk);
    el = m_edge - m_start;     // cycles spent in the current phase
    if (fr) begin
      m_retries = 0; m_lol = 0;
      m_goto(HOLD);
      return;
    end
    case (m_phase)
      HOLD:    if (el == P_HOLD_N) m_goto(WAIT);
      WAIT:    if (ls) m_goto(STABLE); else if (el == P_TIMEOUT) m_retry();
      STABLE:  if (!ls) m_goto(WAIT); else if (el == P_STABLE_N) m_goto(RELEASE);
      RELEASE: if (!ls) m_retry(); else if (el == P_RELEASE_N) m_goto(RUN);
      RUN:     if (!ls) begin m_retries = 0; m_lol = 1; m_goto(HOLD); end
      default: ;
    endcase
  endfunction

  function automatic logic [11:0] model_out();
    logic pll, sys, rdy, fl;
    pll = (m_phase == HOLD) || (m_phase == FAILST);
    sys = (m_phase != RUN);
    rdy = (m_phase == RUN);
    fl  = (m_phase == FAILST);
    return {3'(m_phase), pll, sys, rdy, fl, 4'(m_retries), m_lol};
  endfunction

  // One clock: advance the model with the inputs sampled at the edge, then
  // compare all DUT outputs shortly after the edge.
  task automatic tick();
    @(posedge clkin);
    model_edge(reset, force_relock, lock_in);
    #1;
    if (m_valid)
      check("model", {state, pll_reset, sys_rst, ready, fail, retry_cnt, lol_sticky}, model_out());
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    for (int i = 0; i < budget && state !== tgt; i++) tick();
    check(name, state, tgt);
  endtask

  task automatic count_hold(input string name);
    int n = 0;
    while (pll_reset === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check(name, n, P_HOLD_N);
  endtask

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       pll, sys, rdy, fl;
    logic [3:0] rc;
    logic       lol;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int c;
    int run_left;
    // expected checkpoints of the first lock sequence (lock_in high from cycle 12)
    tbl[0] = '{0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1] = '{7,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[2] = '{8,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[3] = '{14, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[4] = '{15, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[5] = '{18, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[6] = '{19, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[7] = '{20, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[8] = '{21, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[9] = '{22, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};

    reset = 1'b1; lock_in = 1'b0; force_relock = 1'b0;
    m_valid = 0; m_edge = 0;
    tick();
    tick();
    check("reset_state", {state, pll_reset, sys_rst, ready, fail, retry_cnt, lol_sticky},
          {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});

    // 1: first lock sequence, cycle 0 = first cycle with reset released
    reset = 1'b0;
    c = 0;
    for (int i = 0; i < 10; i++) begin
      while (c < tbl[i].cyc) begin
        tick();
        c++;
        if (c == 12) lock_in = 1'b1;
      end
      check("s1_state", state, tbl[i].st);
      check("s1_outs", {pll_reset, sys_rst, ready, fail, retry_cnt, lol_sticky},
            {tbl[i].pll, tbl[i].sys, tbl[i].rdy, tbl[i].fl, tbl[i].rc, tbl[i].lol});
    end

    // 3: lock loss in RUN for 3 cycles
    lock_in = 1'b0;
    tick(); tick(); tick();
    lock_in = 1'b1;
    wait_state(3'(HOLD), 4, "s3_to_hold");
    check("s3_hold_outs", {sys_rst, ready, lol_sticky, retry_cnt}, {1'b1, 1'b0, 1'b1, 4'd0});
    wait_state(3'(RUN), 40, "s3_rerun");
    check("s3_lol_kept", lol_sticky, 1'b1);

    // 2: permanent lock loss -> timeouts -> FAIL
    lock_in = 1'b0;
    wait_state(3'(HOLD), 6, "s2_lol_hold");
    wait_state(3'(WAIT), 12, "s2_wait0");
    wait_state(3'(HOLD), 40, "s2_timeout1");
    check("s2_retry1", retry_cnt, 4'd1);
    wait_state(3'(WAIT), 12, "s2_wait1");
    wait_state(3'(HOLD), 40, "s2_timeout2");
    check("s2_retry2", retry_cnt, 4'd2);
    wait_state(3'(WAIT), 12, "s2_wait2");
    wait_state(3'(FAILST), 40, "s2_fail");
    check("s2_fail_outs", {fail, pll_reset, sys_rst, ready, retry_cnt}, {1'b1, 1'b1, 1'b1, 1'b0, 4'd2});
    lock_in = 1'b1;
    repeat (200) tick();
    check("s2_fail_held", {state, fail}, {3'(FAILST), 1'b1});

    // 5: force_relock out of FAIL
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("s5_force", {state, retry_cnt, fail, lol_sticky, pll_reset}, {3'(HOLD), 4'd0, 1'b0, 1'b0, 1'b1});
    wait_state(3'(RUN), 40, "s5_run");

    // 4: short dropout during STABLE
    lock_in = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    wait_state(3'(WAIT), 12, "s4_wait");
    lock_in = 1'b1;
    wait_state(3'(STABLE), 8, "s4_stable");
    tick();
    lock_in = 1'b0;
    tick();
    tick();
    lock_in = 1'b1;
    check("s4_still_stable", state, 3'(STABLE));
    tick();
    check("s4_back_wait", {state, retry_cnt}, {3'(WAIT), 4'd0});
    wait_state(3'(RUN), 30, "s4_run");
    check("s4_no_retry", retry_cnt, 4'd0);

    // 6: reset mid-RELEASE, then reset together with force_relock
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    wait_state(3'(RELEASE), 30, "s6_release");
    reset = 1'b1;
    tick();
    check("s6_reset_release", {state, pll_reset, sys_rst, ready, fail, retry_cnt, lol_sticky},
          {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
    reset = 1'b0;
    count_hold("s6_hold_len1");
    wait_state(3'(RUN), 30, "s6_run");
    lock_in = 1'b0;
    wait_state(3'(HOLD), 6, "s6_lol");
    wait_state(3'(WAIT), 12, "s6_wait");
    reset = 1'b1;
    force_relock = 1'b1;
    tick();
    check("s6_reset_force", {state, pll_reset, sys_rst, ready, fail, retry_cnt, lol_sticky},
          {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
    reset = 1'b0;
    force_relock = 1'b0;
    count_hold("s6_hold_len2");

    // random lock runs with occasional force_relock/reset, model-checked
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        lock_in  = ($urandom_range(0, 3) != 0);
        run_left = lock_in ? $urandom_range(1, 60) : $urandom_range(1, 14);
      end
      run_left--;
      force_relock = ($urandom_range(0, 79) == 0);
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
